// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// sequential post-reset clear engine that zeroes registers 1..NREGS-1.
module regfile_mp #(
    parameter int XLEN           = 32,   // tracks riscv_pkg::XLEN
    parameter int NREGS          = 32,
    parameter int NRD            = 2,
    parameter int NWR            = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW            = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_PTR  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_PTR = AW'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     clr_ptr_r;
    logic [AW-1:0]     clr_ptr_nxt_s;
    logic              clr_we_s;
    logic              busy_s;

    logic [XLEN-1:0]   mem_r     [NREGS];
    logic [AW-1:0]     rd_addr_s [NRD];
    logic [XLEN-1:0]   rd_data_s [NRD];
    logic [AW-1:0]     wr_addr_s [NWR];
    logic [XLEN-1:0]   wr_data_s [NWR];

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rd_addr_s[i]               = rd_addr[i*AW +: AW];
        assign rd_data[i*XLEN +: XLEN]    = rd_data_s[i];
    end

    for (genvar k = 0; k < NWR; k++) begin : g_wr
        assign wr_addr_s[k] = wr_addr[k*AW +: AW];
        assign wr_data_s[k] = wr_data[k*XLEN +: XLEN];
    end

    assign busy_s = rst | (state_r == ST_CLEAR);
    assign busy   = busy_s;

    // State and clear-pointer register; reset parks the pointer at 1 so the clear starts on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_r <= FIRST_PTR;
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
        end
    end

    // Next-state logic: walk the pointer through every register and return to IDLE after the last.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        clr_we_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_we_s      = 1'b1;
                clr_ptr_nxt_s = clr_ptr_r + FIRST_PTR;
                if (clr_ptr_r == LAST_PTR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_ptr_nxt_s = FIRST_PTR;
            end
        endcase
    end

    // Storage update: clear writes own the array while clearing; ascending port order lets the highest port win.
    always_ff @(posedge clk) begin
        if (!rst && clr_we_s) begin
            mem_r[clr_ptr_r] <= '0;
        end else if (!rst && (state_r == ST_IDLE)) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr_s[k] != '0)) begin
                    mem_r[wr_addr_s[k]] <= wr_data_s[k];
                end
            end
        end
    end

    // Combinational read ports; register 0 and any read while busy return zero.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data_s[i] = '0;
            if (busy_s || (rd_addr_s[i] == '0)) begin
                rd_data_s[i] = '0;
            end else begin
                rd_data_s[i] = mem_r[rd_addr_s[i]];
                for (int k = 0; k < NWR; k++) begin
                    rd_data_s[i] = ((BYPASS != 0) && wr_en[k] && (wr_addr_s[k] == rd_addr_s[i]))
                                   ? wr_data_s[k] : rd_data_s[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: a bypassing 4R/2W instance and a
// non-bypassing 2R/1W instance are checked every cycle against an array model.
module tb_regfile_mp;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  ra_a;
    logic [127:0] rd_a;
    logic [1:0]   we_a;
    logic [9:0]   wa_a;
    logic [63:0]  wd_a;
    logic         busy_a;
    logic [9:0]   ra_b;
    logic [63:0]  rd_b;
    logic [0:0]   we_b;
    logic [4:0]   wa_b;
    logic [31:0]  wd_b;
    logic         busy_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: register contents plus cycles of clear remaining.
    logic [31:0] ma [N];
    logic [31:0] mb [N];
    int          clr_left = N - 1;

    regfile_mp #(.XLEN(32), .NREGS(N), .NRD(4), .NWR(2), .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(ra_a), .rd_data(rd_a),
        .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a), .busy(busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(N), .NRD(2), .NWR(1), .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(ra_b), .rd_data(rd_b),
        .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: reset empties everything and starts an N-1 cycle busy window.
    always @(posedge clk) begin
        if (rst) begin
            clr_left <= N - 1;
            for (int i = 0; i < N; i++) begin
                ma[i] <= 32'd0;
                mb[i] <= 32'd0;
            end
        end else if (clr_left > 0) begin
            clr_left <= clr_left - 1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we_a[k] && wa_a[k*5 +: 5] != 5'd0) ma[wa_a[k*5 +: 5]] <= wd_a[k*32 +: 32];
            if (we_b[0] && wa_b != 5'd0) mb[wa_b] <= wd_b;
        end
    end

    function automatic logic exp_busy();
        return rst || (clr_left > 0);
    endfunction

    function automatic logic [31:0] exp_a(input int i);
        logic [4:0]  a;
        logic [31:0] r;
        a = ra_a[i*5 +: 5];
        if (exp_busy() || a == 5'd0) return 32'd0;
        r = ma[a];
        for (int k = 0; k < 2; k++)
            if (we_a[k] && wa_a[k*5 +: 5] == a) r = wd_a[k*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] exp_b(input int i);
        logic [4:0] a;
        a = ra_b[i*5 +: 5];
        if (exp_busy() || a == 5'd0) return 32'd0;
        return mb[a];
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_a", 128'(busy_a), 128'(exp_busy()));
            chk("busy_b", 128'(busy_b), 128'(exp_busy()));
            for (int i = 0; i < 4; i++) chk($sformatf("rd_a%0d", i), 128'(rd_a[i*32 +: 32]), 128'(exp_a(i)));
            for (int i = 0; i < 2; i++) chk($sformatf("rd_b%0d", i), 128'(rd_b[i*32 +: 32]), 128'(exp_b(i)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_a = 2'b00; wa_a = 10'd0; wd_a = 64'd0;
        we_b = 1'b0;  wa_b = 5'd0;  wd_b = 32'd0;
    endtask

    task automatic read_all(input logic [4:0] a);
        ra_a = {a, a, a, a};
        ra_b = {a, a};
    endtask

    // Pulse reset for one cycle, then count the cycles busy stays high.
    task automatic reset_and_count(output int n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
    endtask

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom);
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        ra_a = 20'd0; ra_b = 10'd0;
        idle_inputs();
        step();
        step();
        chk_en = 1'b1;
        #1;
        chk("reset_busy", 128'(busy_a), 128'(1'b1));
        rst = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin step(); n++; end
        chk("busy_after_reset", 128'(n), 128'(31));

        // Reset clear wipes a written register.
        we_a = 2'b01; wa_a = {5'd0, 5'd5}; wd_a = {32'd0, 32'hDEADBEEF};
        we_b = 1'b1;  wa_b = 5'd5;         wd_b = 32'hDEADBEEF;
        step();
        idle_inputs();
        read_all(5'd5);
        #1;
        chk("x5_written", 128'(rd_a[31:0]), 128'(32'hDEADBEEF));
        reset_and_count(n);
        chk("clear_cycles", 128'(n), 128'(31));
        ra_a = {5'd31, 5'd1, 5'd5, 5'd5};
        #1;
        chk("x5_cleared", 128'(rd_a[31:0]), 128'(32'h0));
        chk("x1_x31_cleared", 128'(rd_a[127:64]), 128'(64'h0));

        // Register 0 ignores writes, with and without bypass.
        we_a = 2'b11; wa_a = 10'd0; wd_a = {2{32'hFFFFFFFF}};
        we_b = 1'b1;  wa_b = 5'd0;  wd_b = 32'hFFFFFFFF;
        read_all(5'd0);
        #1;
        chk("x0_same_cycle", rd_a, 128'd0);
        step();
        idle_inputs();
        #1;
        chk("x0_next_cycle", rd_a, 128'd0);
        chk("x0_b_next_cycle", 128'(rd_b), 128'd0);

        // Bypass on A, stored-value read on B.
        we_a = 2'b01; wa_a = {5'd0, 5'd7}; wd_a = {32'd0, 32'h12345678};
        we_b = 1'b1;  wa_b = 5'd7;         wd_b = 32'h12345678;
        read_all(5'd7);
        #1;
        chk("bypass_a", 128'(rd_a[31:0]), 128'(32'h12345678));
        chk("nobypass_b_pre", 128'(rd_b[31:0]), 128'(32'h0));
        step();
        idle_inputs();
        #1;
        chk("nobypass_b_post", 128'(rd_b[31:0]), 128'(32'h12345678));

        // Same-address conflict: port 1 wins, both for bypass and storage.
        we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h22222222, 32'h11111111};
        read_all(5'd3);
        #1;
        chk("conflict_bypass", rd_a, {4{32'h22222222}});
        step();
        we_a = 2'b11; wa_a = {5'd6, 5'd4}; wd_a = {32'h0000BBBB, 32'hAAAA0000};
        #1;
        chk("conflict_stored", 128'(rd_a[31:0]), 128'(32'h22222222));
        step();
        idle_inputs();
        ra_a = {5'd3, 5'd3, 5'd6, 5'd4};
        #1;
        chk("dual_write", 128'(rd_a[63:0]), 128'({32'h0000BBBB, 32'hAAAA0000}));

        // Write during clear is dropped.
        we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'd0, 32'h5A5A5A5A};
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'd0, 32'hA5A5A5A5};
        we_b = 1'b1;  wa_b = 5'd9;         wd_b = 32'hA5A5A5A5;
        read_all(5'd9);
        #1;
        chk("busy_write_read", 128'(rd_a[31:0]), 128'(32'h0));
        step();
        idle_inputs();
        n = 0;
        while (busy_a && n < 100) begin step(); n++; end
        chk("busy_write_remaining", 128'(n), 128'(26));
        #1;
        chk("x9_dropped", 128'(rd_a[31:0]), 128'(32'h0));
        chk("x9_dropped_b", 128'(rd_b[31:0]), 128'(32'h0));

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst  = ($urandom_range(0, 149) == 0);
            we_a = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wa_a[k*5 +: 5]  = raddr();
                wd_a[k*32 +: 32] = $urandom;
            end
            for (int i = 0; i < 4; i++) ra_a[i*5 +: 5] = raddr();
            we_b = 1'($urandom);
            wa_b = raddr();
            wd_b = $urandom;
            for (int i = 0; i < 2; i++) ra_b[i*5 +: 5] = raddr();
            step();
        end
        rst = 1'b0;
        idle_inputs();
        n = 0;
        while (busy_a && n < 100) begin step(); n++; end

        // Fill every register, then reset mid-clear and confirm a full restart.
        for (int r = 1; r < N; r++) begin
            we_a = 2'b01; wa_a = {5'd0, 5'(r)}; wd_a = {32'd0, 32'hC0DE0000 | 32'(r)};
            we_b = 1'b1;  wa_b = 5'(r);         wd_b = 32'hBEEF0000 | 32'(r);
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (9) step();
        reset_and_count(n);
        chk("restart_cycles", 128'(n), 128'(31));
        for (int r = 0; r < N; r++) begin
            read_all(5'(r));
            #1;
            chk("final_zero_a", rd_a, 128'd0);
            chk("final_zero_b", 128'(rd_b), 128'd0);
            step();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
